// File: rtl/alu_multi_latency.sv
// Integer ALU unit: one exec slot with per-class latency feeding an in-order output FIFO.
// Latency: LOW_LAT cycles for arith/logic/branch ops, HIGH_LAT cycles for shifts (accept edge to out_valid).
// Backpressure: in_ready drops while the slot is busy or the FIFO is full; a finished op waits in the slot for FIFO space.
module alu_multi_latency #(
    parameter int DATA_W    = 32,
    parameter int PREG_W    = 6,
    parameter int TAG_W     = 5,
    parameter int ADDR_W    = 32,
    parameter int LOW_LAT   = 1,
    parameter int HIGH_LAT  = 3,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src1_val,
    input  logic [DATA_W-1:0] src2_val,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [3:0]        alu_op,
    input  logic [PREG_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_val,
    output logic [PREG_W-1:0] out_addr,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_is_br,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_target
);

    localparam int SH_W    = $clog2(DATA_W);
    localparam int MAX_LAT = (HIGH_LAT > LOW_LAT) ? HIGH_LAT : LOW_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    localparam logic [CNT_W-1:0] LOW_LD  = CNT_W'(LOW_LAT - 1);
    localparam logic [CNT_W-1:0] HIGH_LD = CNT_W'(HIGH_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(OUT_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic [PREG_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic              is_br;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } res_t;

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    res_t              slot;
    res_t              fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;

    logic [DATA_W-1:0] op_b, imm_x2;
    logic [SH_W-1:0]   shamt;
    logic              is_br, is_shift, cond, lt_s, lt_u, eq;
    res_t              res_d;
    logic              accept, push, pop, fifo_full;

    always_comb begin
        is_br    = (alu_op >= 4'd10);
        is_shift = (alu_op == 4'd2) || (alu_op == 4'd6) || (alu_op == 4'd7);
        // Branches compare registers; the immediate is only their offset.
        op_b     = (use_imm && !is_br) ? imm : src2_val;
        shamt    = op_b[SH_W-1:0];
        lt_s     = $signed(src1_val) < $signed(op_b);
        lt_u     = src1_val < op_b;
        eq       = src1_val == op_b;
        imm_x2   = imm << 1;
        cond     = 1'b0;
        res_d    = '0;
        case (alu_op)
            4'd0:  res_d.val = src1_val + op_b;
            4'd1:  res_d.val = src1_val - op_b;
            4'd2:  res_d.val = src1_val << shamt;
            4'd3:  res_d.val = {{(DATA_W-1){1'b0}}, lt_s};
            4'd4:  res_d.val = {{(DATA_W-1){1'b0}}, lt_u};
            4'd5:  res_d.val = src1_val ^ op_b;
            4'd6:  res_d.val = src1_val >> shamt;
            4'd7:  res_d.val = DATA_W'($signed(src1_val) >>> shamt);
            4'd8:  res_d.val = src1_val | op_b;
            4'd9:  res_d.val = src1_val & op_b;
            4'd10: cond = eq;
            4'd11: cond = !eq;
            4'd12: cond = lt_s;
            4'd13: cond = !lt_s;
            4'd14: cond = lt_u;
            4'd15: cond = !lt_u;
            default: ;
        endcase
        res_d.addr   = dst_addr;
        res_d.tag    = tag_in;
        res_d.is_br  = is_br;
        res_d.taken  = cond;
        res_d.target = cond ? (pc_in + ADDR_W'(imm_x2)) : '0;
    end

    assign fifo_full = (fifo_cnt == DEPTH_C);
    assign in_ready  = reset & ~flush & ~busy & (fifo_cnt < DEPTH_C);
    assign accept    = in_valid & in_ready;
    assign pop       = reset & ~flush & (fifo_cnt != '0) & out_ready;
    // A full FIFO still takes the slot when its head leaves on the same edge.
    assign push      = reset & ~flush & busy & (cnt == '0) & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy     <= 1'b0;
            cnt      <= '0;
            slot     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            busy     <= 1'b0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (accept) begin
                busy <= 1'b1;
                slot <= res_d;
                cnt  <= is_shift ? HIGH_LD : LOW_LD;
            end else if (push) begin
                busy <= 1'b0;
            end else if (busy && cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + OCC_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - OCC_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= slot;
    end

    // Outputs read as zero whenever the queue is empty or reset is held.
    always_comb begin
        out_valid = reset & (fifo_cnt != '0);
        out_val   = out_valid ? fifo_mem[rd_ptr].val    : '0;
        out_addr  = out_valid ? fifo_mem[rd_ptr].addr   : '0;
        out_tag   = out_valid ? fifo_mem[rd_ptr].tag    : '0;
        out_is_br = out_valid & fifo_mem[rd_ptr].is_br;
        br_taken  = out_valid & fifo_mem[rd_ptr].taken;
        br_target = out_valid ? fifo_mem[rd_ptr].target : '0;
    end

endmodule

// File: tb/tb_alu_multi_latency.sv
// Bench for alu_multi_latency: directed latency/backpressure/flush/reset scenarios plus randomized ops
// checked in order against an arithmetic reference model.
module tb_alu_multi_latency;
    localparam int LOW_LAT  = 1;
    localparam int HIGH_LAT = 3;

    logic        clk, reset, flush, in_valid, in_ready, use_imm, out_valid, out_ready;
    logic [31:0] src1_val, src2_val, imm, pc_in, out_val, br_target;
    logic [3:0]  alu_op;
    logic [5:0]  dst_addr, out_addr;
    logic [4:0]  tag_in, out_tag;
    logic        out_is_br, br_taken;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] val;
        logic [5:0]  addr;
        logic [4:0]  tag;
        logic        is_br;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t exp_q[$];

    alu_multi_latency #(
        .DATA_W(32), .PREG_W(6), .TAG_W(5), .ADDR_W(32),
        .LOW_LAT(LOW_LAT), .HIGH_LAT(HIGH_LAT), .OUT_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1_val(src1_val), .src2_val(src2_val), .imm(imm), .use_imm(use_imm),
        .alu_op(alu_op), .dst_addr(dst_addr), .pc_in(pc_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_val(out_val), .out_addr(out_addr), .out_tag(out_tag),
        .out_is_br(out_is_br), .br_taken(br_taken), .br_target(br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference semantics in 64-bit integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b2,
                                   input logic [31:0] im, input logic ui, input logic [31:0] pc,
                                   input logic [5:0] dst, input logic [4:0] tg);
        exp_t   e;
        longint ua, ub, sa, sb, p;
        int     sh;
        logic   c;
        ua = longint'(a);
        ub = longint'((ui && op < 4'd10) ? im : b2);
        sa = longint'($signed(a));
        sb = longint'($signed(ub[31:0]));
        sh = int'(ub % 32);
        p  = longint'(1) << sh;
        c  = 1'b0;
        e.val = 32'd0;
        case (op)
            4'd0:  e.val = 32'(ua + ub);
            4'd1:  e.val = 32'(ua - ub);
            4'd2:  e.val = 32'(ua * p);
            4'd3:  e.val = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  e.val = (ua < ub) ? 32'd1 : 32'd0;
            4'd5:  e.val = 32'(ua ^ ub);
            4'd6:  e.val = 32'(ua / p);
            4'd7:  e.val = 32'((sa >= 0) ? sa / p : (sa - (p - 1)) / p);
            4'd8:  e.val = 32'(ua | ub);
            4'd9:  e.val = 32'(ua & ub);
            4'd10: c = (ua == ub);
            4'd11: c = (ua != ub);
            4'd12: c = (sa < sb);
            4'd13: c = (sa >= sb);
            4'd14: c = (ua < ub);
            4'd15: c = (ua >= ub);
            default: ;
        endcase
        e.addr   = dst;
        e.tag    = tg;
        e.is_br  = (op >= 4'd10);
        e.taken  = c;
        e.target = c ? 32'(longint'(pc) + 2 * longint'(im)) : 32'd0;
        return e;
    endfunction

    // Present an op at a negedge, wait for in_ready, let one edge accept it, return at the next negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic ui, input logic [31:0] pc,
                         input logic [5:0] dst, input logic [4:0] tg);
        int guard;
        alu_op = op; src1_val = a; src2_val = b; imm = im; use_imm = ui;
        pc_in = pc; dst_addr = dst; tag_in = tg; in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL issue_ready_timeout got in_ready=%0b want 1", in_ready);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(model(op, a, b, im, ui, pc, dst, tg));
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        while (!out_valid && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_val, out_addr, out_tag, out_is_br, br_taken, br_target} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b rdy=%0b val=%h want all 0", out_valid, in_ready, out_val);
        end
        in_valid = 1'b0; reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%0b valid=%0b want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_add_latency();
        int n;
        out_ready = 1'b1;
        issue(4'd0, 32'd5, 32'd7, 32'h55, 1'b0, 32'h40, 6'd9, 5'd17);
        wait_valid(10, n);
        checks++;
        if (n !== LOW_LAT) begin
            errors++;
            $display("FAIL add_latency got %0d want %0d", n, LOW_LAT);
        end
        checks++;
        if (out_val !== 32'd12 || out_tag !== 5'd17 || out_addr !== 6'd9 || out_is_br !== 1'b0) begin
            errors++;
            $display("FAIL add_result got val=%0d tag=%0d addr=%0d br=%0b want 12 17 9 0",
                     out_val, out_tag, out_addr, out_is_br);
        end
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_sra_latency();
        int n;
        out_ready = 1'b1;
        issue(4'd7, 32'h8000_0000, 32'h1234_5678, 32'd4, 1'b1, 32'h0, 6'd3, 5'd4);
        wait_valid(10, n);
        checks++;
        if (n !== HIGH_LAT) begin
            errors++;
            $display("FAIL sra_latency got %0d want %0d", n, HIGH_LAT);
        end
        checks++;
        if (out_val !== 32'hF800_0000) begin
            errors++;
            $display("FAIL sra_result got %h want f8000000", out_val);
        end
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_compares();
        logic [3:0]  t_op  [5] = '{4'd3, 4'd4, 4'd14, 4'd10, 4'd12};
        logic [31:0] t_a   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'hFFFF_FFFF};
        logic [31:0] t_b   [5] = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'd3, 32'd1};
        logic [31:0] t_im  [5] = '{32'd0, 32'd0, 32'd8, 32'd8, 32'hFFFF_FFFC};
        logic        t_ui  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] t_pc  [5] = '{32'h0, 32'h0, 32'h100, 32'h100, 32'h200};
        logic [31:0] w_val [5] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        logic        w_br  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        w_tk  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] w_tg  [5] = '{32'h0, 32'h0, 32'h110, 32'h0, 32'h1F8};
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_im[i], t_ui[i], t_pc[i], 6'(i), 5'(i + 20));
            wait_valid(10, n);
            checks++;
            if (out_valid !== 1'b1 || out_val !== w_val[i] || out_is_br !== w_br[i] ||
                br_taken !== w_tk[i] || br_target !== w_tg[i]) begin
                errors++;
                $display("FAIL compare_case%0d got v=%0b val=%h br=%0b tk=%0b tgt=%h want 1 %h %0b %0b %h",
                         i, out_valid, out_val, out_is_br, br_taken, br_target,
                         w_val[i], w_br[i], w_tk[i], w_tg[i]);
            end
            @(negedge clk);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   got;
        bit   acc;
        out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 32'h0, 6'd1, 5'd1);
        issue(4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 32'h0, 6'd2, 5'd2);
        alu_op = 4'd0; src1_val = 32'd100; src2_val = 32'd200; use_imm = 1'b0;
        dst_addr = 6'd3; tag_in = 5'd3; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_val !== 32'd3 || out_tag !== 5'd1) begin
                errors++;
                $display("FAIL stall_hold c%0d got rdy=%0b v=%0b val=%0d tag=%0d want 0 1 3 1",
                         c, in_ready, out_valid, out_val, out_tag);
            end
        end
        out_ready = 1'b1;
        got = 0; acc = 1'b0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (out_val !== e.val || out_tag !== e.tag || out_addr !== e.addr) begin
                    errors++;
                    $display("FAIL drain_order n%0d got val=%0d tag=%0d want %0d %0d",
                             got, out_val, out_tag, e.val, e.tag);
                end
            end
            if (!acc && in_valid && in_ready) begin
                exp_q.push_back(model(4'd0, 32'd100, 32'd200, 32'd0, 1'b0, 32'h0, 6'd3, 5'd3));
                acc = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (got !== 3 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL drain_count got %0d want 3", got);
        end
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic flush_and_check(input string name);
        int seen;
        alu_op = 4'd0; src1_val = 32'd77; src2_val = 32'd1; tag_in = 5'd30; in_valid = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_during got %0b want 0", name, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after got v=%0b rdy=%0b want 0 1", name, out_valid, in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL %s_leak got %0d outputs want 0", name, seen);
        end
        exp_q.delete();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 32'h0, 6'd1, 5'd1);
        issue(4'd7, 32'hF000_0000, 32'd2, 32'd0, 1'b0, 32'h0, 6'd2, 5'd2);
        flush_and_check("flush_busy");
        out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 32'h0, 6'd1, 5'd1);
        issue(4'd0, 32'd2, 32'd2, 32'd0, 1'b0, 32'h0, 6'd2, 5'd2);
        @(negedge clk);
        flush_and_check("flush_full");
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b0;
        issue(4'd0, 32'd4, 32'd4, 32'd0, 1'b0, 32'h0, 6'd5, 5'd5);
        issue(4'd2, 32'd1, 32'd5, 32'd0, 1'b0, 32'h0, 6'd6, 5'd6);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_val, out_addr, out_tag, out_is_br, br_taken, br_target} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got v=%0b rdy=%0b val=%h want all 0", out_valid, in_ready, out_val);
        end
        reset = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready got %0b want 1", in_ready);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_stale got %0d outputs want 0", seen);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [3:0]  op;
                    logic [31:0] a, b, im;
                    logic        ui;
                    op = 4'($urandom_range(0, 15));
                    a  = $urandom;
                    b  = $urandom;
                    im = $urandom;
                    ui = 1'($urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        b  = a;
                        im = a;
                    end
                    issue(op, a, b, im, ui, $urandom, 6'($urandom), 5'($urandom));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                exp_t e;
                int   cyc = 0;
                while ((!done || exp_q.size() > 0) && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_unexpected got val=%h tag=%0d want no output", out_val, out_tag);
                        end else begin
                            e = exp_q.pop_front();
                            if ({out_val, out_tag, out_addr, out_is_br, br_taken, br_target} !==
                                {e.val, e.tag, e.addr, e.is_br, e.taken, e.target}) begin
                                errors++;
                                $display("FAIL rand_result got val=%h tag=%0d br=%0b tk=%0b tgt=%h want %h %0d %0b %0b %h",
                                         out_val, out_tag, out_is_br, br_taken, br_target,
                                         e.val, e.tag, e.is_br, e.taken, e.target);
                            end
                        end
                    end
                end
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL rand_drain_timeout got %0d pending want 0", exp_q.size());
                end
            end
        join
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use_imm = 1'b0;
        src1_val = '0; src2_val = '0; imm = '0; alu_op = '0; dst_addr = '0; pc_in = '0; tag_in = '0;
        @(negedge clk);
        test_reset();
        test_add_latency();
        test_sra_latency();
        test_compares();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
